// File: rtl/digit_entry_composer_if.sv
// ---------------------------------------------------------------------------
// digit_entry_composer_if
//   Bundle of the front-panel entry signals between the panel (buttons,
//   display/consumer side) and digit_entry_composer.
//
//   Handshake: there is no ready/valid backpressure on this block. The raw
//   buttons are asynchronous levels sampled by the composer; valid_o is a
//   single-cycle pulse that marks the cycle in which seconds_o has just taken
//   a new value, and the consumer must capture it in that cycle because no
//   acknowledgement is expected.
//
//   Signals
//     btn_next_i / btn_inc_i / btn_load_i : raw buttons (panel -> composer)
//     digit1_o .. digit4_o                 : BCD digits being edited
//     sel_o                                : selected digit, 0 = digit1
//     seconds_o                            : last committed seconds value
//     valid_o                              : one-cycle commit pulse
//     overflow_o                           : last commit exceeded MAX_VALUE
//     busy_o                               : conversion in progress
//     dbg_state_o                          : FSM state (0 = EDIT, 1 = CONVERT)
//
//   Modports
//     master : panel / testbench side (drives buttons)
//     slave  : digit_entry_composer side (drives everything else)
// ---------------------------------------------------------------------------
interface digit_entry_composer_if;
    logic        btn_next_i;
    logic        btn_inc_i;
    logic        btn_load_i;
    logic [3:0]  digit1_o;
    logic [3:0]  digit2_o;
    logic [3:0]  digit3_o;
    logic [3:0]  digit4_o;
    logic [1:0]  sel_o;
    logic [12:0] seconds_o;
    logic        valid_o;
    logic        overflow_o;
    logic        busy_o;
    logic        dbg_state_o;

    modport master (
        output btn_next_i, btn_inc_i, btn_load_i,
        input  digit1_o, digit2_o, digit3_o, digit4_o, sel_o,
        input  seconds_o, valid_o, overflow_o, busy_o, dbg_state_o
    );

    modport slave (
        input  btn_next_i, btn_inc_i, btn_load_i,
        output digit1_o, digit2_o, digit3_o, digit4_o, sel_o,
        output seconds_o, valid_o, overflow_o, busy_o, dbg_state_o
    );
endinterface

// File: rtl/digit_entry_composer.sv
// ---------------------------------------------------------------------------
// digit_entry_composer
//   Front-panel entry path for the stopwatch/timer. Three raw buttons are
//   synchronised and debounced; the user edits four BCD digits (digit1 =
//   thousands .. digit4 = ones) and a load press composes them into a 13-bit
//   binary seconds value over four CONVERT cycles.
//
//   Ports
//     clk_i  : system clock, all logic on its rising edge
//     reset  : asynchronous, active-high reset
//     bus    : digit_entry_composer_if.slave (buttons in; digits, sel,
//              seconds, valid, overflow, busy, debug state out)
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive stable cycles before a level is accepted
//     MAX_VALUE       : largest committable value; larger entries flag overflow
//     REPEAT_CYCLES   : hold time per auto-repeat increment
//
//   Optional feature
//     AUTOREPEAT_EN   : when defined, holding inc in EDIT produces an extra
//                       increment every REPEAT_CYCLES cycles. When undefined
//                       there is one increment per press and no repeat counter.
// ---------------------------------------------------------------------------
module digit_entry_composer #(
    parameter int DEBOUNCE_CYCLES = 20800,
    parameter int MAX_VALUE       = 8191,
    parameter int REPEAT_CYCLES   = 520000
) (
    input  logic                   clk_i,
    input  logic                   reset,
    digit_entry_composer_if.slave  bus
);

    // Reject configurations that the datapath widths cannot honour.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (MAX_VALUE < 0 || MAX_VALUE > 8191) begin : g_bad_max
        $error("MAX_VALUE must fit in the 13-bit seconds output");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        EDIT    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning. Bit 0 = next, bit 1 = inc, bit 2 = load.
    // ------------------------------------------------------------------
    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    stable_q;
    logic [2:0]    stable_d;
    logic [2:0]    rise_d;
    logic [2:0]    evt_q;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];

    assign raw = {bus.btn_load_i, bus.btn_inc_i, bus.btn_next_i};

    // The stable level only follows the synchronised level after it has
    // disagreed for DEBOUNCE_CYCLES cycles in a row; any agreeing cycle
    // restarts the count. rise_d marks the cycle the stable level goes high.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        for (int b = 0; b < 3; b++) begin
            deb_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (deb_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[b] = sync2_q[b];
                    rise_d[b]   = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            evt_q    <= '0;
            for (int b = 0; b < 3; b++) begin
                deb_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            evt_q    <= rise_d;
            for (int b = 0; b < 3; b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM state and datapath registers.
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] acc_step;
    logic [3:0]  digit_q [4];
    logic [3:0]  digit_d [4];
    logic [1:0]  sel_q, sel_d;
    logic [12:0] seconds_q, seconds_d;
    logic        valid_q, valid_d;
    logic        overflow_q, overflow_d;

    logic next_evt;
    logic inc_evt;
    logic load_evt;

    assign next_evt = evt_q[0];
    assign load_evt = evt_q[2];

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_evt_q, rep_evt_d;

    // Counts cycles while inc is held in EDIT; the counter is held at zero
    // on release, on a load event and throughout CONVERT.
    always_comb begin
        rep_cnt_d = '0;
        rep_evt_d = 1'b0;
        if (state_q == EDIT && stable_q[1] && !load_evt) begin
            if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
                rep_evt_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= '0;
            rep_evt_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_evt_q <= rep_evt_d;
        end
    end

    assign inc_evt = evt_q[1] | rep_evt_q;
`else
    assign inc_evt = evt_q[1];
`endif

    // Horner step: digit1 enters first, so after four steps acc holds the
    // full decimal value (at most 9999, hence 14 bits).
    assign acc_step = (acc_q * 14'd10) + {10'd0, digit_q[idx_q]};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        digit_d    = digit_q;
        sel_d      = sel_q;
        seconds_d  = seconds_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            EDIT: begin
                if (load_evt) begin
                    state_d = CONVERT;
                    acc_d   = '0;
                    idx_d   = '0;
                end else if (inc_evt) begin
                    digit_d[sel_q] = (digit_q[sel_q] == 4'd9) ? 4'd0
                                                             : digit_q[sel_q] + 4'd1;
                end else if (next_evt) begin
                    sel_d = sel_q + 2'd1;
                end
            end
            CONVERT: begin
                // Button events arriving here are simply dropped.
                acc_d = acc_step;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = EDIT;
                    if (acc_step <= 14'(MAX_VALUE)) begin
                        seconds_d  = acc_step[12:0];
                        valid_d    = 1'b1;
                        overflow_d = 1'b0;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q    <= EDIT;
            idx_q      <= '0;
            acc_q      <= '0;
            sel_q      <= '0;
            seconds_q  <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            sel_q      <= sel_d;
            seconds_q  <= seconds_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    assign bus.digit1_o    = digit_q[0];
    assign bus.digit2_o    = digit_q[1];
    assign bus.digit3_o    = digit_q[2];
    assign bus.digit4_o    = digit_q[3];
    assign bus.sel_o       = sel_q;
    assign bus.seconds_o   = seconds_q;
    assign bus.valid_o     = valid_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.busy_o      = (state_q == CONVERT);
    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_digit_entry_composer.sv
// ---------------------------------------------------------------------------
// tb_digit_entry_composer
//   Directed bench for digit_entry_composer with DEBOUNCE_CYCLES = 4 and
//   REPEAT_CYCLES = 16. A model of the four digits and the selection is kept
//   alongside the stimulus; committed values are queued when a load is
//   driven and popped when valid_o pulses.
// ---------------------------------------------------------------------------
module tb_digit_entry_composer;

    localparam int DEB = 4;
    localparam int REP = 16;

    // Raw press to first busy sample: 2 sync flops + DEB debounce + 1 event reg.
    localparam int LOAD_TO_BUSY = 2 + DEB + 1;

`ifdef AUTOREPEAT_EN
    localparam int HOLD_INCS = 4;
`else
    localparam int HOLD_INCS = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    digit_entry_composer_if bus ();

    digit_entry_composer #(
        .DEBOUNCE_CYCLES (DEB),
        .MAX_VALUE       (8191),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp;
    int          m_dig [4];
    int          m_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every valid_o pulse must match the oldest queued commit.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.valid_o !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, bus.valid_o}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("seconds_on_valid", {19'd0, bus.seconds_o}, {19'd0, mon_exp});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic check_panel(input string tag);
        check({tag, "_digit1"}, {28'd0, bus.digit1_o}, m_dig[0]);
        check({tag, "_digit2"}, {28'd0, bus.digit2_o}, m_dig[1]);
        check({tag, "_digit3"}, {28'd0, bus.digit3_o}, m_dig[2]);
        check({tag, "_digit4"}, {28'd0, bus.digit4_o}, m_dig[3]);
        check({tag, "_sel"},    {30'd0, bus.sel_o},    m_sel);
    endtask

    task automatic drive_btn(input int which, input logic lvl);
        case (which)
            0:       bus.btn_next_i = lvl;
            1:       bus.btn_inc_i  = lvl;
            default: bus.btn_load_i = lvl;
        endcase
    endtask

    // Hold a button long enough to be accepted, then let the release settle.
    task automatic press(input int which, input int hold);
        @(negedge clk);
        drive_btn(which, 1'b1);
        repeat (hold) @(negedge clk);
        drive_btn(which, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic tap_inc();
        press(1, 8);
        m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
        check_panel("inc");
    endtask

    task automatic tap_next();
        press(0, 8);
        m_sel = (m_sel + 1) % 4;
        check_panel("next");
    endtask

    task automatic goto_sel(input int k);
        while (m_sel != k) tap_next();
    endtask

    task automatic set_digit(input int k, input int v);
        goto_sel(k);
        while (m_dig[k] != v) tap_inc();
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        set_digit(0, a);
        set_digit(1, b);
        set_digit(2, c);
        set_digit(3, d);
    endtask

    // Press load and check the CONVERT timing and commit outcome. With
    // inc_during set, inc is raised so its event lands inside CONVERT.
    task automatic do_load(input logic commit, input logic [12:0] val,
                           input logic [12:0] prev, input logic inc_during);
        int k;
        int busy_n;
        if (commit) exp_q.push_back(val);
        @(negedge clk);
        bus.btn_load_i = 1'b1;
        k = 0;
        while (bus.busy_o !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
            if (inc_during && k == 2) bus.btn_inc_i = 1'b1;
        end
        check("load_to_busy_cycles", k, LOAD_TO_BUSY);
        busy_n = 0;
        while (bus.busy_o === 1'b1 && busy_n < 10) begin
            @(negedge clk);
            busy_n++;
        end
        check("busy_cycles", busy_n, 4);
        check("valid_after_convert", {31'd0, bus.valid_o}, {31'd0, commit});
        check("overflow_after_convert", {31'd0, bus.overflow_o}, {31'd0, ~commit});
        check("seconds_after_convert", {19'd0, bus.seconds_o}, {19'd0, commit ? val : prev});
        @(negedge clk);
        check("valid_one_cycle", {31'd0, bus.valid_o}, 32'd0);
        bus.btn_load_i = 1'b0;
        bus.btn_inc_i  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        reset          = 1'b1;
        bus.btn_next_i = 1'b0;
        bus.btn_inc_i  = 1'b0;
        bus.btn_load_i = 1'b0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_sel = 0;

        repeat (3) @(negedge clk);
        check_panel("reset");
        check("reset_seconds",  {19'd0, bus.seconds_o},  0);
        check("reset_valid",    {31'd0, bus.valid_o},    0);
        check("reset_overflow", {31'd0, bus.overflow_o}, 0);
        check("reset_busy",     {31'd0, bus.busy_o},     0);
        check("reset_state",    {31'd0, bus.dbg_state_o}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of a conversion.
        tap_inc();
        tap_next();
        bus.btn_load_i = 1'b1;
        k = 0;
        while (bus.busy_o !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("midrun_busy_seen", {31'd0, bus.busy_o}, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.btn_load_i = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, bus.busy_o}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_sel = 0;
        check_panel("after_midrun_reset");
        check("midrun_seconds", {19'd0, bus.seconds_o}, 0);
        repeat (20) @(negedge clk);
        check("midrun_no_valid", {31'd0, bus.valid_o}, 0);

        // Basic entry and commit, then recommit of the same digits.
        enter(1, 2, 3, 4);
        do_load(1'b1, 13'd1234, 13'd0, 1'b0);
        do_load(1'b1, 13'd1234, 13'd1234, 1'b0);
        check_panel("retained_after_commit");

        // Digit wrap on digit3, selection wrap.
        set_digit(2, 0);
        for (int i = 0; i < 10; i++) tap_inc();
        check("digit3_wrapped", {28'd0, bus.digit3_o}, 0);
        goto_sel(0);
        for (int i = 0; i < 4; i++) tap_next();
        check("sel_wrapped", {30'd0, bus.sel_o}, 0);

        // Overflow, then largest legal value.
        enter(1, 2, 3, 4);
        do_load(1'b1, 13'd1234, 13'd1234, 1'b0);
        enter(9, 9, 9, 9);
        do_load(1'b0, 13'd0, 13'd1234, 1'b0);
        enter(8, 1, 9, 1);
        do_load(1'b1, 13'd8191, 13'd1234, 1'b0);

        // A 3-cycle glitch on inc is rejected.
        @(negedge clk);
        bus.btn_inc_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_inc_i = 1'b0;
        repeat (15) @(negedge clk);
        check_panel("glitch");

        // inc and next together: only inc applies.
        @(negedge clk);
        bus.btn_inc_i  = 1'b1;
        bus.btn_next_i = 1'b1;
        repeat (8) @(negedge clk);
        bus.btn_inc_i  = 1'b0;
        bus.btn_next_i = 1'b0;
        repeat (12) @(negedge clk);
        m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
        check_panel("inc_and_next");

        // inc pressed during CONVERT is discarded.
        enter(0, 4, 5, 6);
        do_load(1'b1, 13'd456, 13'd8191, 1'b1);
        check_panel("inc_during_convert");

        // Long hold on inc.
        goto_sel(1);
        @(negedge clk);
        bus.btn_inc_i = 1'b1;
        repeat (2 + DEB + 50) @(negedge clk);
        bus.btn_inc_i = 1'b0;
        repeat (12) @(negedge clk);
        m_dig[1] = (m_dig[1] + HOLD_INCS) % 10;
        check_panel("long_hold");

        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
